// File: rtl/vlut_prog_pkg.sv
// Shared definitions for the programmable value lookup table: default row
// contents, the restore FSM state encoding and the truncating default helper.
package vlut_prog_pkg;

  localparam int unsigned ZERO   = 0;
  localparam int unsigned ONE    = 1;
  localparam int unsigned THIRTY = 2;
  localparam int unsigned SIXTY  = 3;

  localparam int unsigned DEF_ZERO   = 0;
  localparam int unsigned DEF_ONE    = 1;
  localparam int unsigned DEF_THIRTY = 30;
  localparam int unsigned DEF_SIXTY  = 60;

  typedef enum logic {IDLE, SWEEP} state_t;

  // Power-on content of a row, reduced modulo 2**dw; rows past SIXTY are 0.
  function automatic int unsigned lut_default(input int unsigned row, input int unsigned dw);
    int unsigned v;
    case (row)
      ZERO:    v = DEF_ZERO;
      ONE:     v = DEF_ONE;
      THIRTY:  v = DEF_THIRTY;
      SIXTY:   v = DEF_SIXTY;
      default: v = 0;
    endcase
    if (dw < 32) v = v & ((32'd1 << dw) - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/vlut_restore_fsm.sv
// Restore sequencer: walks ptr over every implemented row, one row per cycle,
// and tells the parent which row to reload with its default.
module vlut_restore_fsm
  import vlut_prog_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              restore,
  output logic              busy,
  output logic              sw_en,
  output logic [ADDR_W-1:0] sw_row
);

  // ptr carries one extra bit so DEPTH == 2**ADDR_W never wraps.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] ptr, ptr_nxt;

  // State, pointer and the registered busy flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= (state_nxt == SWEEP);
    end
  end

  // Next-state: restore is only looked at while idle; the sweep ends after
  // the edge that reloads the last implemented row.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sw_en     = 1'b0;
    sw_row    = ptr[ADDR_W-1:0];
    case (state)
      IDLE: begin
        if (restore) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        sw_en = 1'b1;
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + (ADDR_W+1)'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/vlut_prog.sv
// Runtime-programmable row -> value table with a registered, write-first read
// port and a sequential restore-to-defaults sweep.
module vlut_prog
  import vlut_prog_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdRow,
  output logic [DATA_W-1:0] Value,
  output logic              Valid,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrRow,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Restore,
  output logic              Busy
);

  localparam int              NROWS   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic              sw_en;
  logic [ADDR_W-1:0] sw_row;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  // Contents and defaults spread over the full pointer range; rows past
  // DEPTH read as constant 0 so any pointer value indexes safely.
  logic [DATA_W-1:0] rd_tab   [NROWS];
  logic [DATA_W-1:0] dflt_tab [NROWS];

  vlut_restore_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fsm (
    .Clk     (Clk),
    .Reset   (Reset),
    .restore (Restore),
    .busy    (Busy),
    .sw_en   (sw_en),
    .sw_row  (sw_row)
  );

  // Host writes only land when idle, not racing a restore request, and in range.
  assign wr_ok = !Busy && WrEn && !Restore && ({1'b0, WrRow} < DEPTH_W);

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    localparam logic [DATA_W-1:0] DFLT = DATA_W'(lut_default(r, DATA_W));
    if (r < DEPTH) begin : g_impl
      logic [DATA_W-1:0] q;
      // Row storage: reset and sweep reload the default, otherwise host write.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                       q <= DFLT;
        else if (sw_en && (sw_row == ADDR_W'(r)))        q <= DFLT;
        else if (wr_ok && (WrRow == ADDR_W'(r)))         q <= WrData;
      end
      assign rd_tab[r]   = q;
      assign dflt_tab[r] = DFLT;
    end else begin : g_none
      assign rd_tab[r]   = '0;
      assign dflt_tab[r] = '0;
    end
  end

  // Write-first bypass: a row being written this edge reads the new value.
  always_comb begin
    rd_data = rd_tab[RdRow];
    if (sw_en && (sw_row == RdRow))      rd_data = dflt_tab[RdRow];
    else if (wr_ok && (WrRow == RdRow))  rd_data = WrData;
  end

  // Read register: Valid pulses per read, Value holds between reads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Value <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= RdEn;
      if (RdEn) Value <= rd_data;
    end
  end

endmodule

// File: tb/tb_vlut_prog.sv
// Directed bench for vlut_prog: a default 8-bit/8-row build plus a 5-bit,
// 6-row build for truncation and out-of-range behaviour.
module tb_vlut_prog;

  logic       Clk, Reset;
  logic       RdEn, WrEn, Restore;
  logic [2:0] RdRow, WrRow;
  logic [7:0] WrData, Value;
  logic       Valid, Busy;

  logic       b_rden, b_wren, b_restore;
  logic [2:0] b_rdrow, b_wrrow;
  logic [4:0] b_wrdata, b_value;
  logic       b_valid, b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  vlut_prog dut (
    .Clk(Clk), .Reset(Reset), .RdEn(RdEn), .RdRow(RdRow), .Value(Value), .Valid(Valid),
    .WrEn(WrEn), .WrRow(WrRow), .WrData(WrData), .Restore(Restore), .Busy(Busy)
  );

  vlut_prog #(.ADDR_W(3), .DATA_W(5), .DEPTH(6)) dut2 (
    .Clk(Clk), .Reset(Reset), .RdEn(b_rden), .RdRow(b_rdrow), .Value(b_value), .Valid(b_valid),
    .WrEn(b_wren), .WrRow(b_wrrow), .WrData(b_wrdata), .Restore(b_restore), .Busy(b_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic       rden;
    logic [2:0] rdrow;
    logic       wren;
    logic [2:0] wrrow;
    logic [7:0] wrdata;
    logic       exp_valid;
    logic [7:0] exp_value;
  } vec_t;

  vec_t vt[10];
  int   n;

  initial begin
    vt[0] = '{1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0};
    vt[1] = '{1'b1, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1, 8'd1};
    vt[2] = '{1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 8'd30};
    vt[3] = '{1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 1'b1, 8'd60};
    vt[4] = '{1'b1, 3'd7, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0};
    vt[5] = '{1'b0, 3'd0, 1'b1, 3'd2, 8'hA5, 1'b0, 8'd0};
    vt[6] = '{1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 8'hA5};
    vt[7] = '{1'b1, 3'd3, 1'b1, 3'd3, 8'h42, 1'b1, 8'h42};
    vt[8] = '{1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h42};
    vt[9] = '{1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1, 8'd0};

    RdEn = 0; RdRow = 0; WrEn = 0; WrRow = 0; WrData = 0; Restore = 0;
    b_rden = 0; b_rdrow = 0; b_wren = 0; b_wrrow = 0; b_wrdata = 0; b_restore = 0;

    // Reset state
    Reset = 1'b1;
    #3;
    check("reset_value", Value, 0);
    check("reset_valid", Valid, 0);
    check("reset_busy",  Busy, 0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // Table vectors: default reads, write, write-first, hold
    for (int i = 0; i < 10; i++) begin
      RdEn = vt[i].rden; RdRow = vt[i].rdrow;
      WrEn = vt[i].wren; WrRow = vt[i].wrrow; WrData = vt[i].wrdata;
      tick();
      check($sformatf("vec%0d_valid", i), Valid, vt[i].exp_valid);
      check($sformatf("vec%0d_value", i), Value, vt[i].exp_value);
    end
    RdEn = 0; WrEn = 0;

    // Restore sweep with row 5 observed every cycle
    for (int r = 0; r < 8; r++) begin
      WrEn = 1; WrRow = 3'(r); WrData = 8'hF0 + 8'(r);
      tick();
    end
    WrEn = 0;
    Restore = 1; RdEn = 1; RdRow = 3'd5;
    tick();
    Restore = 0;
    check("sweep_start_busy", Busy, 1);
    check("sweep_start_row5", Value, 8'hF5);
    for (int p = 0; p < 8; p++) begin
      tick();
      check($sformatf("sweep_p%0d_row5", p), Value, (p < 5) ? 8'hF5 : 8'h00);
      check($sformatf("sweep_p%0d_busy", p), Busy, (p < 7) ? 1 : 0);
    end
    for (int r = 0; r < 4; r++) begin
      RdRow = 3'(r);
      tick();
      check($sformatf("post_sweep_row%0d", r), Value, (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 30 : 60);
    end
    RdEn = 0;

    // Write and second restore during a sweep are ignored
    Restore = 1;
    tick();
    Restore = 0;
    n = Busy ? 1 : 0;
    for (int k = 0; k < 20 && Busy; k++) begin
      WrEn = (k == 2); WrRow = 3'd1; WrData = 8'h77;
      Restore = (k == 2 || k == 3);
      tick();
      if (Busy) n++;
    end
    WrEn = 0; Restore = 0;
    check("sweep2_len", n, 8);
    RdEn = 1; RdRow = 3'd1;
    tick();
    check("sweep2_row1", Value, 1);
    RdEn = 0;

    // Asynchronous reset in the middle of a sweep
    for (int r = 0; r < 8; r++) begin
      WrEn = 1; WrRow = 3'(r); WrData = 8'hF0 + 8'(r);
      tick();
    end
    WrEn = 0;
    Restore = 1;
    tick();
    Restore = 0; RdEn = 1; RdRow = 3'd6;
    for (int p = 0; p < 4; p++) tick();
    check("midsweep_busy_pre", Busy, 1);
    check("midsweep_value_pre", Value, 8'hF6);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_busy",  Busy, 0);
    check("async_rst_valid", Valid, 0);
    check("async_rst_value", Value, 0);
    #1 Reset = 1'b0;
    for (int r = 4; r < 8; r++) begin
      RdRow = 3'(r);
      tick();
      check($sformatf("after_rst_row%0d", r), Value, 0);
    end
    check("after_rst_busy", Busy, 0);
    RdEn = 0;

    // Narrow, shallow build
    b_rden = 1; b_rdrow = 3'd3;
    tick();
    check("b_row3_value", b_value, 28);
    check("b_row3_valid", b_valid, 1);
    b_wren = 1; b_wrrow = 3'd6; b_wrdata = 5'h15; b_rdrow = 3'd6;
    tick();
    b_wren = 0;
    check("b_row6_same_edge", b_value, 0);
    check("b_row6_valid", b_valid, 1);
    tick();
    check("b_row6_after", b_value, 0);
    b_rdrow = 3'd2;
    tick();
    check("b_row2", b_value, 30);
    b_rdrow = 3'd0;
    tick();
    check("b_row0", b_value, 0);
    b_rden = 0;
    b_wren = 1; b_wrrow = 3'd1; b_wrdata = 5'h1F;
    tick();
    b_wren = 0;
    b_rden = 1; b_rdrow = 3'd1;
    tick();
    check("b_row1_written", b_value, 5'h1F);
    b_rden = 0;
    b_restore = 1;
    tick();
    b_restore = 0;
    n = b_busy ? 1 : 0;
    for (int k = 0; k < 20 && b_busy; k++) begin
      tick();
      if (b_busy) n++;
    end
    check("b_sweep_len", n, 6);
    b_rden = 1; b_rdrow = 3'd1;
    tick();
    check("b_row1_restored", b_value, 1);
    b_rden = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
